// File: rtl/key_player_pkg.sv
// Shared types for the key sequence player and the lock-side symbol decoding.
package key_player_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } player_state_t;

  typedef enum logic {
    SYM_A = 1'b0,
    SYM_B = 1'b1
  } symbol_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_sequence_player_if.sv
// Control handshake and key lines between a controller and the key sequence player.
interface key_sequence_player_if #(
  parameter int unsigned MAX_LEN = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic [MAX_LEN-1:0] code;
  logic [LEN_W-1:0]   len;
  logic               abort;
  logic               key_a;
  logic               key_b;
  logic               busy;
  logic               done;

  modport master (
    output start, code, len, abort,
    input  key_a, key_b, busy, done
  );

  modport slave (
    input  start, code, len, abort,
    output key_a, key_b, busy, done
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; zero flags the final cycle of the loaded phase.
module phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == WIDTH'(1));

endmodule

// File: rtl/key_sequence_player.sv
// Plays a latched A/B symbol sequence as clean key pulses separated by quiet gaps.
module key_sequence_player
  import key_player_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic                  clock,
  input logic                  reset,
  key_sequence_player_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(max_u(PULSE_CYCLES, GAP_CYCLES) + 1);

  player_state_t      state_q;
  player_state_t      state_d;
  logic [MAX_LEN-1:0] code_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   eff_len;
  logic [IDX_W-1:0]   index_q;
  logic [IDX_W-1:0]   index_d;
  logic               latch_en;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               phase_zero;
  logic               last_symbol;

  // Clamp keeps the index inside the code register, so it never wraps.
  assign eff_len     = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
  assign last_symbol = ((LEN_W'(index_q) + LEN_W'(1)) == len_q);

  phase_timer #(
    .WIDTH (CNT_W)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (phase_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q <= '0;
      code_q  <= '0;
      len_q   <= '0;
    end else begin
      index_q <= index_d;
      if (latch_en) begin
        code_q <= bus.code;
        len_q  <= eff_len;
      end
    end
  end

  // Next state; abort overrides everything including start.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    latch_en    = 1'b0;
    timer_load  = 1'b0;
    timer_value = CNT_W'(PULSE_CYCLES);
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            latch_en = 1'b1;
            index_d  = '0;
            if (eff_len == '0) begin
              state_d = DONE;
            end else begin
              state_d    = PRESS;
              timer_load = 1'b1;
            end
          end
        end
        PRESS: begin
          if (phase_zero) begin
            state_d     = RELEASE;
            timer_load  = 1'b1;
            timer_value = CNT_W'(GAP_CYCLES);
          end
        end
        RELEASE: begin
          if (phase_zero) begin
            if (last_symbol) begin
              state_d = DONE;
            end else begin
              state_d    = PRESS;
              index_d    = index_q + IDX_W'(1);
              timer_load = 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state; no input reaches them.
  always_comb begin
    bus.key_a = 1'b0;
    bus.key_b = 1'b0;
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == DONE);
    if (state_q == PRESS) begin
      if (symbol_t'(code_q[index_q]) == SYM_B) begin
        bus.key_b = 1'b1;
      end else begin
        bus.key_a = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_sequence_player.sv
// Random and directed playback checked by a scoreboard against a timing model of the player.
module tb_key_sequence_player;

  localparam int P    = 2;
  localparam int G    = 3;
  localparam int PG   = P + G;
  localparam int MAXL = 8;

  typedef struct {
    int cyc;
    int kind;  // 0 = A press, 1 = B press, 2 = done
  } ev_t;

  logic clock;
  logic reset;
  int   edge_cnt = 0;

  key_sequence_player_if #(.MAX_LEN(MAXL)) bus ();

  key_sequence_player #(
    .MAX_LEN      (MAXL),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference model: current run and expected output events.
  ev_t        q[$];
  int         run_start = -10;
  int         run_done  = -10;
  int         run_len   = 0;
  logic [7:0] run_code  = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cur_code = '0;
  logic [3:0] cur_len  = '0;

  int  lock_prog     = 0;
  int  lock_open_cyc = -1;
  int  last_done_cyc = -1;
  bit  prev_a = 1'b0;
  bit  prev_b = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
  endtask

  task automatic model_edge(input int e, input bit st, input logic [7:0] cd,
                            input logic [3:0] ln, input bit ab, input bit rs);
    int l;
    if (rs || ab) begin
      if (run_done > e) run_done = e;
      while (q.size() > 0 && q[$].cyc > e) void'(q.pop_back());
    end else if (st && !(run_start < e && e <= run_done)) begin
      l = (int'(ln) > MAXL) ? MAXL : int'(ln);
      run_start = e;
      run_len   = l;
      run_code  = cd;
      for (int i = 0; i < l; i++) q.push_back('{cyc: e + 1 + i * PG, kind: int'(cd[i])});
      q.push_back('{cyc: e + 1 + l * PG, kind: 2});
      run_done = e + 1 + l * PG;
    end
  endtask

  task automatic step(input bit st, input logic [7:0] cd, input logic [3:0] ln,
                      input bit ab, input bit rs);
    bus.start = st;
    bus.code  = cd;
    bus.len   = ln;
    bus.abort = ab;
    reset     = rs;
    model_edge(edge_cnt, st, cd, ln, ab, rs);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, cur_code, cur_len, 1'b0, 1'b0);
  endtask

  task automatic pop_event(input int kind, input int c);
    ev_t e;
    if (q.size() == 0) begin
      chk(1'b0, "unexpected_event", kind, -1);
    end else begin
      e = q.pop_front();
      chk(e.kind == kind && e.cyc == c, "event_kind_cycle", kind * 10000 + c, e.kind * 10000 + e.cyc);
    end
  endtask

  // Monitor: sample away from the active edge, compare with the model.
  always @(negedge clock) begin : monitor
    int c, off, idx;
    bit ea, eb, eb_busy, rise;
    if (edge_cnt >= 1) begin
      c = edge_cnt;
      while (q.size() > 0 && q[0].cyc < c) begin
        chk(1'b0, "missed_event", -1, q[0].kind);
        void'(q.pop_front());
      end
      eb_busy = (run_start < c && c <= run_done);
      ea = 1'b0;
      eb = 1'b0;
      if (eb_busy) begin
        off = c - run_start - 1;
        idx = off / PG;
        if (idx < run_len && (off % PG) < P) begin
          if (run_code[idx]) eb = 1'b1;
          else ea = 1'b1;
        end
      end
      chk(bus.busy == eb_busy, "busy", int'(bus.busy), int'(eb_busy));
      chk({bus.key_a, bus.key_b} == {ea, eb}, "keys_ab", int'({bus.key_a, bus.key_b}), int'({ea, eb}));
      rise = (bus.key_a || bus.key_b) && !(prev_a || prev_b);
      if (rise) begin
        pop_event(bus.key_b ? 1 : 0, c);
        if (int'(bus.key_b) == ((lock_prog % 2 == 1) ? 1 : 0)) lock_prog++;
        else lock_prog = bus.key_a ? 1 : 0;
        if (lock_prog == 4) begin
          lock_open_cyc = c;
          lock_prog = 0;
        end
      end
      if (bus.done) begin
        pop_event(2, c);
        last_done_cyc = c;
      end
      prev_a = bus.key_a;
      prev_b = bus.key_b;
    end
  end

  initial begin : driver
    int e0;
    bus.start = 1'b0;
    bus.code  = '0;
    bus.len   = '0;
    bus.abort = 1'b0;
    reset     = 1'b1;
    repeat (3) step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    idle(2);

    // A,B,A,B into the lock detector
    lock_prog = 0;
    cur_code = 8'b0000_1010; cur_len = 4'd4;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(25);
    chk(lock_open_cyc == e0 + 16, "lock_open_cycle", lock_open_cyc, e0 + 16);
    chk(last_done_cyc - lock_open_cyc == PG, "done_after_open", last_done_cyc - lock_open_cyc, PG);
    chk(last_done_cyc == e0 + 21, "done_cycle_len4", last_done_cyc, e0 + 21);

    // Zero length
    cur_len = 4'd0;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(4);
    chk(last_done_cyc == e0 + 1, "done_cycle_len0", last_done_cyc, e0 + 1);

    // Length clamp
    cur_code = 8'hFF; cur_len = 4'd12;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(44);
    chk(last_done_cyc == e0 + 41, "done_cycle_clamped", last_done_cyc, e0 + 41);

    // Code change and restart while busy, then start right after done
    cur_code = 8'b0000_1010; cur_len = 4'd4;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(2);
    cur_code = 8'hF5;
    idle(2);
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    while (edge_cnt < e0 + 22) idle(1);
    cur_code = 8'h02; cur_len = 4'd2;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(14);
    chk(last_done_cyc == e0 + 22 + 1 + 2 * PG, "back_to_back_done", last_done_cyc, e0 + 33);

    // Abort then reset during the second press
    cur_code = 8'b0000_1010; cur_len = 4'd4;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    while (edge_cnt < e0 + 6) idle(1);
    step(1'b0, cur_code, cur_len, 1'b1, 1'b0);
    idle(25);
    chk(last_done_cyc < e0, "no_done_after_abort", last_done_cyc, e0 - 1);
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    while (edge_cnt < e0 + 6) idle(1);
    step(1'b0, cur_code, cur_len, 1'b0, 1'b1);
    idle(25);
    chk(last_done_cyc < e0, "no_done_after_reset", last_done_cyc, e0 - 1);
    cur_code = 8'h05; cur_len = 4'd3;
    e0 = edge_cnt;
    step(1'b1, cur_code, cur_len, 1'b0, 1'b0);
    idle(18);
    chk(last_done_cyc == e0 + 1 + 3 * PG, "restart_after_reset", last_done_cyc, e0 + 1 + 3 * PG);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cur_code = 8'($urandom);
      cur_len  = 4'($urandom_range(0, 12));
      step($urandom_range(0, 3) == 0, cur_code, cur_len,
           $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
    end
    idle(60);
    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
